data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 29 ++
 rtl/data_mem_resp_ram.sv | 28 ++
 rtl/data_mem_resp.sv | 128 ++++++++++++
 tb/tb_data_mem_resp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder: bus types, control
// constants and the handshake FSM state encoding.
package data_mem_resp_pkg;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef logic [31:0] RegBus;
    typedef logic [31:0] DataAddrBus;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

    // Wait-state count as loaded into the 4-bit counter; values outside
    // 0..15 are clamped so a bad parameter cannot silently wrap.
    function automatic logic [3:0] wait_load(input int ws);
        if (ws < 0)
            return 4'd0;
        else if (ws > 15)
            return 4'd15;
        else
            return 4'(ws);
    endfunction

endpackage

// File: rtl/data_mem_resp_ram.sv
// Word storage as four independent byte banks. Each bank has its own write
// enable and a registered read port; contents are never reset.
module data_ram_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] r_mem [0:(1<<ADDR_W)-1];
        logic [7:0] r_rd;

        // Byte-lane write and registered read of this bank
        always_ff @(posedge clk) begin
            if (i_we[b])
                r_mem[i_waddr] <= i_wdata[8*b +: 8];
            r_rd <= r_mem[i_raddr];
        end

        assign o_rdata[8*b +: 8] = r_rd;
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder for the MEM stage: latches one request, waits
// WAIT_STATES cycles, performs the access and pulses ack for one cycle.
// ce falling while busy flushes the request without side effects.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  DataAddrBus  addr,
    input  logic [3:0]  sel,
    input  RegBus       data_i,
    output RegBus       data_o,
    output logic        ack,
    output logic        err,
    output logic        stallreq
);

    localparam logic [3:0] CNT_LOAD = wait_load(WAIT_STATES);

    mem_state_e  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_sel;
    DataAddrBus  r_addr;
    RegBus       r_wdata;
    RegBus       r_data_o;
    logic        r_ack;
    logic        r_err;

    logic              w_oor;
    logic              w_access;
    logic [3:0]        w_ram_we;
    logic [ADDR_W-1:0] w_raddr;
    RegBus             w_rdata;

    // Anything above the implemented word range is an error response.
    assign w_oor    = |r_addr[31:ADDR_W+2];
    // The access edge: last busy cycle with the requester still present.
    assign w_access = (r_state == S_BUSY) && (ce == ChipEnable) && (r_cnt == 4'd0);
    assign w_ram_we = {4{w_access && (r_we == WriteEnable) && !w_oor}} & r_sel;

    // In IDLE the read port tracks the live address so the word is already
    // sitting in the bank read registers by the time the access edge arrives,
    // even with zero wait states. After that it follows the latched address
    // so late input changes cannot disturb the read.
    assign w_raddr = (r_state == S_IDLE) ? addr[ADDR_W+1:2] : r_addr[ADDR_W+1:2];

    data_ram_array #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_addr[ADDR_W+1:2]),
        .i_wdata (r_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Request handshake FSM with registered data_o/ack/err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_sel    <= 4'd0;
            r_addr   <= ZeroWord;
            r_wdata  <= ZeroWord;
            r_data_o <= ZeroWord;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                    r_data_o <= ZeroWord;
                    if (ce == ChipEnable) begin
                        r_we    <= we;
                        r_sel   <= sel;
                        r_addr  <= addr;
                        r_wdata <= data_i;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (ce != ChipEnable) begin
                        // Pipeline flush: drop the request, nothing written.
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ack    <= 1'b1;
                        r_err    <= w_oor;
                        r_data_o <= (w_oor || r_we == WriteEnable) ? ZeroWord : w_rdata;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // ce still high here belongs to the finished request.
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                    r_data_o <= ZeroWord;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                    r_data_o <= ZeroWord;
                    r_cnt    <= 4'd0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign data_o   = r_data_o;
    assign ack      = r_ack;
    assign err      = r_err;
    assign stallreq = ce & ~r_ack;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: two instances (1 and 3 wait
// states) sharing stimulus, a per-instance word model, directed scenarios
// followed by randomized traffic.
module tb_data_mem_resp;

    localparam int AW  = 10;
    localparam int WS0 = 1;
    localparam int WS1 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, we;
    logic [31:0] addr, data_i;
    logic [3:0]  sel;
    bit          cur;

    logic        ce0, ce1;
    logic [31:0] do0, do1;
    logic        ack0, ack1, err0, err1, st0, st1;

    logic [31:0] dm;
    logic        am, em, sm;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [2][16];

    assign ce0 = ce & ~cur;
    assign ce1 = ce & cur;
    assign dm  = cur ? do1  : do0;
    assign am  = cur ? ack1 : ack0;
    assign em  = cur ? err1 : err0;
    assign sm  = cur ? st1  : st0;

    data_mem_resp #(.ADDR_W(AW), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .rst(rst_n), .ce(ce0), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(do0), .ack(ack0), .err(err0), .stallreq(st0)
    );

    data_mem_resp #(.ADDR_W(AW), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rst(rst_n), .ce(ce1), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(do1), .ack(ack1), .err(err1), .stallreq(st1)
    );

    always #5 clk = ~clk;

    function automatic int ws_of(input bit u);
        return u ? WS1 : WS0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request; ce held until ack, and beyond it when hold=1.
    task automatic do_req(input bit u, input bit w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input bit hold, input bit wiggle);
        bit          oor;
        int          idx;
        int          lat;
        int          k;
        bit          got;
        logic [31:0] exp_d;
        oor = (a >> (AW + 2)) != 0;
        idx = int'((a >> 2) & 32'd15);
        exp_d = (oor || w) ? 32'd0 : mem_m[u][idx];
        lat = ws_of(u) + 2;
        cur = u; ce = 1'b1; we = w; addr = a; sel = s; data_i = d;
        got = 1'b0; k = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            chk("stallreq", 32'(sm), 32'(k != lat));
            if (am) begin
                got = 1'b1;
                chk("latency", 32'(k), 32'(lat));
                chk("data_o", dm, exp_d);
                chk("err", 32'(em), 32'(oor));
            end else begin
                chk("idle_data_o", dm, 32'd0);
                chk("idle_err", 32'(em), 32'd0);
                @(posedge clk); #1;
                k++;
                if (wiggle) begin
                    we = 1'($urandom); addr = $urandom; sel = 4'($urandom); data_i = $urandom;
                end
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        if (w && !oor)
            for (int b = 0; b < 4; b++)
                if (s[b]) mem_m[u][idx][8*b +: 8] = d[8*b +: 8];
        @(posedge clk); #1;
        if (!hold) ce = 1'b0;
    endtask

    // Start a full-word write, drop ce after kdrop edges, expect no response.
    task automatic do_abort(input bit u, input int widx, input logic [31:0] d, input int kdrop);
        cur = u; ce = 1'b1; we = 1'b1; addr = 32'(widx * 4); sel = 4'hF; data_i = d;
        repeat (kdrop) begin @(posedge clk); #1; end
        ce = 1'b0;
        repeat (WS1 + 4) begin
            @(negedge clk);
            chk("abort_ack", 32'(am), 32'd0);
            chk("abort_err", 32'(em), 32'd0);
            chk("abort_data_o", dm, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          u;
        rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0; cur = 1'b0;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        chk("rst_data_o0", do0, 32'd0);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_stall0", 32'(st0), 32'd0);
        chk("rst_data_o1", do1, 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every modelled word a known value
        for (int uu = 0; uu < 2; uu++)
            for (int i = 0; i < 16; i++)
                do_req(1'(uu), 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b1, 1'b0);
        ce = 1'b0;
        @(posedge clk); #1;

        // Full-word write then read back
        do_req(1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b0, 1'b0);

        // Single byte lane write, read with sel ignored
        do_req(1'b0, 1'b1, 32'h0000_0010, 4'b0100, 32'h00AA_0000, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 32'h0000_0010, 4'b0001, 32'h0, 1'b0, 1'b0);

        // Out-of-range write and read; word 0 (aliased index) untouched
        do_req(1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 1'b0);

        // Aborted writes leave old contents
        do_abort(1'b1, 7, 32'hCAFE_F00D, 2);
        do_req(1'b1, 1'b0, 32'd28, 4'hF, 32'h0, 1'b0, 1'b0);
        do_abort(1'b1, 8, 32'h0BAD_0BAD, 4);
        do_req(1'b1, 1'b0, 32'd32, 4'hF, 32'h0, 1'b0, 1'b0);
        do_abort(1'b0, 3, 32'hFACE_FACE, 2);
        do_req(1'b0, 1'b0, 32'd12, 4'hF, 32'h0, 1'b0, 1'b0);

        // Reset pulse in the middle of a busy write
        cur = 1'b1; ce = 1'b1; we = 1'b1; addr = 32'd20; sel = 4'hF; data_i = 32'h5555_AAAA;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("rstmid_data_o", dm, 32'd0);
        chk("rstmid_ack", 32'(am), 32'd0);
        chk("rstmid_err", 32'(em), 32'd0);
        ce = 1'b0;
        @(negedge clk);
        chk("rstmid_stall", 32'(sm), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'd20, 4'hF, 32'h0, 1'b0, 1'b0);

        // Back-to-back reads with ce held through DONE
        for (int i = 0; i < 4; i++) do_req(1'b0, 1'b0, 32'(i * 4), 4'hF, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 32'(i * 8), 4'hF, 32'h0, 1'b1, 1'b0);
        ce = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic, including input churn while busy
        for (int n = 0; n < 80; n++) begin
            u = 1'($urandom);
            case ($urandom_range(0, 7))
                0:       a = 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
                1:       a = $urandom | 32'h8000_0000;
                default: a = {26'd0, 4'($urandom), 2'($urandom)};
            endcase
            do_req(u, 1'($urandom), a, 4'($urandom), $urandom, 1'($urandom), 1'($urandom));
        end
        ce = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
